nic: RTL and testbench
======================

# nic

Network interface controller between one processing node and its ring router port in the 4-node CMP. Exposes four 64-bit memory-mapped registers to the processor (input channel buffer/status, output channel buffer/status) and moves single-flit 64-bit packets to and from the router with a send/ready handshake. One-entry buffer per direction. The processor polls status registers; there is no interrupt.

## Interface

Parameters:
- DATA_W, 64, flit and processor data width.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- addr  input  [0:1]  processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  [0:63]  processor write data.
- d_out  output  [0:63]  processor read data.
- nicEn  input  1  NIC access enable.
- nicWrEn  input  1  write enable; qualified by nicEn.
- net_si  input  1  router sending a flit to the NIC.
- net_ri  output  1  NIC can accept a flit.
- net_di  input  [0:63]  flit from router.
- net_so  output  1  NIC sending a flit to the router.
- net_ro  input  1  router can accept a flit.
- net_do  output  [0:63]  flit to router.
- net_polarity  input  1  router virtual-channel phase for the current cycle.

## Operation

- State: in_buf[0:63], in_full; out_buf[0:63], out_full; net_so/net_do output registers.
- Bit 0 of a flit is its VC bit; bit 63 is the LSB.
- Input channel:
  - net_ri = ~in_full (combinational).
  - net_si && ~in_full: latch net_di into in_buf, set in_full.
  - net_si while in_full: protocol violation; flit dropped, state unchanged.
  - Processor read of addr 00 (nicEn=1, nicWrEn=0): d_out = in_buf; in_full clears at that edge. Read while empty returns the stale in_buf and leaves in_full=0.
- Output channel:
  - Processor write of addr 10 (nicEn=1, nicWrEn=1) with out_full=0: load d_in into out_buf, set out_full.
  - Write while out_full=1: dropped, out_buf unchanged.
  - Writes to 00, 01, 11: ignored.
  - Injection condition: out_full && net_ro && (out_buf[0] == net_polarity). At that edge: net_so<=1, net_do<=out_buf, out_full<=0. Otherwise net_so<=0; net_do holds its value.
- Status reads: addr 01 returns {63'b0, in_full}; addr 11 returns {63'b0, out_full}; in both the flag is at bit 63.
- d_out is combinational from addr and state when nicEn && ~nicWrEn, otherwise 64'b0. Read of addr 10 returns 64'b0.
- Simultaneous events:
  - A processor write in the same cycle as injection sees out_full=1 and is dropped. Software re-polls.
  - A processor read of addr 00 in the same cycle as a router arrival cannot occur, because net_ri=0 while in_full=1.

## Timing

- Reset (RESET=0, asynchronous): in_full=0, out_full=0, in_buf=0, out_buf=0, net_so=0, net_do=0.
  - Resulting outputs: net_ri=1; d_out=0 unless a read is active.
- Router to processor: flit accepted at edge N; status 01 reads 1 from after edge N.
- Processor to router:
  - Write accepted at edge N.
  - Earliest net_so=1 is the cycle after edge N+1, i.e. one cycle after out_full rises, provided net_ro is high and polarity matches.
  - net_so is high for exactly one cycle per flit.
- Throughput: at most one flit per direction every 2 cycles, limited by the single buffer.
- Reset asserted mid-transfer: the pending flit in either buffer is discarded and net_so drops immediately.

## Test plan

- Reset release: RESET low then high -> net_ri=1, net_so=0, net_do=0; reads of 01 and 11 return 0.
- Inbound:
  - net_si=1, net_di=64'hDEAD_BEEF_0000_0001 -> next cycle net_ri=0, read 01 returns 1, read 00 returns DEAD_BEEF_0000_0001.
  - After the read edge: net_ri=1, read 01 returns 0.
- Outbound, polarity match:
  - Write 10 with 64'h8000_0000_0000_00AA, net_ro=1.
  - net_polarity=0 for 3 cycles: out stays full, net_so=0.
  - net_polarity=1: one-cycle net_so=1 with net_do=8000_0000_0000_00AA; status 11 returns 0 afterwards.
- Back-pressure: out_full=1 and net_ro=0 for 10 cycles -> no net_so. A second write of 64'h1234 is dropped. After net_ro=1 the original flit is sent.
- Inbound overflow: in_full=1 and net_si=1 with new data -> in_buf keeps the old value, net_ri stays 0.
- Mid-operation reset: out_full=1 and in_full=1, pull RESET low asynchronously between edges -> both flags clear immediately, net_ri=1, and no flit is sent after release.

Source files
------------

// File: rtl/nic_if.sv
// Node/NIC boundary: processor register port plus the router flit port.
// The master side is the environment (processor and router); the NIC itself is the slave.
interface nic_if #(
   parameter int DATA_W = 64
);
   logic [0:1]        addr;
   logic [0:DATA_W-1] d_in;
   logic [0:DATA_W-1] d_out;
   logic              nicEn;
   logic              nicWrEn;
   logic              net_si;
   logic              net_ri;
   logic [0:DATA_W-1] net_di;
   logic              net_so;
   logic              net_ro;
   logic [0:DATA_W-1] net_do;
   logic              net_polarity;

   modport master (
      output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      input  d_out, net_ri, net_so, net_do
   );

   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      output d_out, net_ri, net_so, net_do
   );
endinterface

// File: rtl/nic.sv
// Ring NIC: one-flit input and output buffers exposed to the processor as four
// polled registers, with a send/ready flit handshake toward the router port.
module nic #(
   parameter int DATA_W = 64
) (
   input  logic CLK,
   input  logic RESET,
   nic_if.slave bus
);
   logic [0:DATA_W-1] r_inBuf;
   logic [0:DATA_W-1] r_outBuf;
   logic [0:DATA_W-1] r_netDo;
   logic              r_inFull;
   logic              r_outFull;
   logic              r_netSo;

   logic              w_rdEn;
   logic              w_wrEn;
   logic              w_accept;
   logic              w_readIn;
   logic              w_loadOut;
   logic              w_inject;
   logic [0:DATA_W-1] w_dOut;

   assign w_rdEn    = bus.nicEn && !bus.nicWrEn;
   assign w_wrEn    = bus.nicEn && bus.nicWrEn;
   assign w_accept  = bus.net_si && !r_inFull;
   assign w_readIn  = w_rdEn && (bus.addr == 2'b00);
   assign w_loadOut = w_wrEn && (bus.addr == 2'b10) && !r_outFull;
   // A flit may only leave in the router phase that matches its VC bit (bit 0).
   assign w_inject  = r_outFull && bus.net_ro && (r_outBuf[0] == bus.net_polarity);

   // An arrival into an empty buffer takes precedence over a read of stale data.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_inBuf  <= '0;
         r_inFull <= 1'b0;
      end else if (w_accept) begin
         r_inBuf  <= bus.net_di;
         r_inFull <= 1'b1;
      end else if (w_readIn) begin
         r_inFull <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_outBuf  <= '0;
         r_outFull <= 1'b0;
         r_netSo   <= 1'b0;
         r_netDo   <= '0;
      end else begin
         r_netSo <= w_inject;
         if (w_inject) begin
            r_netDo   <= r_outBuf;
            r_outFull <= 1'b0;
         end else if (w_loadOut) begin
            r_outBuf  <= bus.d_in;
            r_outFull <= 1'b1;
         end
      end
   end

   // Status flags sit in the least significant bit (index DATA_W-1).
   always_comb begin
      w_dOut = '0;
      if (w_rdEn) begin
         case (bus.addr)
            2'b00:   w_dOut = r_inBuf;
            2'b01:   w_dOut = {{(DATA_W-1){1'b0}}, r_inFull};
            2'b11:   w_dOut = {{(DATA_W-1){1'b0}}, r_outFull};
            default: w_dOut = '0;
         endcase
      end
   end

   assign bus.d_out  = w_dOut;
   assign bus.net_ri = !r_inFull;
   assign bus.net_so = r_netSo;
   assign bus.net_do = r_netDo;
endmodule

// File: tb/tb_nic.sv
// Bench for nic: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the two single-flit channels.
module tb_nic;
   logic clk = 1'b0;
   logic rst_n;

   int checks = 0;
   int failures = 0;

   nic_if #(.DATA_W(64)) bus ();

   nic #(.DATA_W(64)) u_dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: each direction is a queue holding at most one flit.
   logic [63:0] inQ[$];
   logic [63:0] outQ[$];
   logic [63:0] lastIn = '0;
   logic [63:0] lastSent = '0;
   logic        expSo = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inQ.delete();
         outQ.delete();
         lastIn   = '0;
         lastSent = '0;
         expSo    = 1'b0;
      end else begin
         automatic bit procRead  = bus.nicEn && !bus.nicWrEn;
         automatic bit procWrite = bus.nicEn && bus.nicWrEn;
         automatic int outBefore = outQ.size();
         expSo = 1'b0;
         if (inQ.size() == 0 && bus.net_si) begin
            inQ.push_back(bus.net_di);
            lastIn = bus.net_di;
         end else if (procRead && bus.addr == 2'd0 && inQ.size() != 0) begin
            void'(inQ.pop_front());
         end
         if (outBefore != 0 && bus.net_ro && (outQ[0][63] == bus.net_polarity)) begin
            lastSent = outQ.pop_front();
            expSo    = 1'b1;
         end
         if (procWrite && bus.addr == 2'd2 && outBefore == 0)
            outQ.push_back(bus.d_in);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic compareModel();
      logic [63:0] expOut;
      expOut = '0;
      if (bus.nicEn && !bus.nicWrEn) begin
         case (bus.addr)
            2'd0:    expOut = lastIn;
            2'd1:    expOut = 64'(inQ.size());
            2'd3:    expOut = 64'(outQ.size());
            default: expOut = '0;
         endcase
      end
      checkOutput("model_d_out", bus.d_out, expOut);
      checkOutput("model_net_ri", 64'(bus.net_ri), (inQ.size() == 0) ? 64'd1 : 64'd0);
      checkOutput("model_net_so", 64'(bus.net_so), 64'(expSo));
      checkOutput("model_net_do", bus.net_do, lastSent);
   endtask

   task automatic applyStimulus(input logic [1:0] a, input logic [63:0] din, input logic en,
                                input logic wr, input logic si, input logic [63:0] di,
                                input logic ro, input logic pol);
      @(posedge clk);
      #1;
      bus.addr         = a;
      bus.d_in         = din;
      bus.nicEn        = en;
      bus.nicWrEn      = wr;
      bus.net_si       = si;
      bus.net_di       = di;
      bus.net_ro       = ro;
      bus.net_polarity = pol;
      @(negedge clk);
      compareModel();
   endtask

   task automatic procRead(input logic [1:0] a, input logic ro, input logic pol);
      applyStimulus(a, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, ro, pol);
   endtask

   task automatic procWrite(input logic [1:0] a, input logic [63:0] d, input logic ro, input logic pol);
      applyStimulus(a, d, 1'b1, 1'b1, 1'b0, 64'd0, ro, pol);
   endtask

   task automatic routerSend(input logic [63:0] d);
      applyStimulus(2'd0, 64'd0, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.addr         = 2'd0;
      bus.d_in         = '0;
      bus.nicEn        = 1'b0;
      bus.nicWrEn      = 1'b0;
      bus.net_si       = 1'b0;
      bus.net_di       = '0;
      bus.net_ro       = 1'b0;
      bus.net_polarity = 1'b0;

      applyStimulus(2'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      applyStimulus(2'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset release
      procRead(2'd1, 1'b0, 1'b0);
      checkOutput("rst_net_ri", 64'(bus.net_ri), 64'd1);
      checkOutput("rst_net_so", 64'(bus.net_so), 64'd0);
      checkOutput("rst_net_do", bus.net_do, 64'd0);
      checkOutput("rst_status_in", bus.d_out, 64'd0);
      procRead(2'd3, 1'b0, 1'b0);
      checkOutput("rst_status_out", bus.d_out, 64'd0);

      // Inbound flit
      routerSend(64'hDEAD_BEEF_0000_0001);
      procRead(2'd1, 1'b0, 1'b0);
      checkOutput("in_net_ri_full", 64'(bus.net_ri), 64'd0);
      checkOutput("in_status_full", bus.d_out, 64'd1);
      procRead(2'd0, 1'b0, 1'b0);
      checkOutput("in_read_data", bus.d_out, 64'hDEAD_BEEF_0000_0001);
      procRead(2'd1, 1'b0, 1'b0);
      checkOutput("in_net_ri_after_read", 64'(bus.net_ri), 64'd1);
      checkOutput("in_status_after_read", bus.d_out, 64'd0);

      // Outbound with polarity gating
      procWrite(2'd2, 64'h8000_0000_0000_00AA, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         procRead(2'd3, 1'b1, 1'b0);
         checkOutput("out_wait_status", bus.d_out, 64'd1);
         checkOutput("out_wait_so", 64'(bus.net_so), 64'd0);
      end
      procRead(2'd3, 1'b1, 1'b1);
      checkOutput("out_pol_so_pre", 64'(bus.net_so), 64'd0);
      procRead(2'd3, 1'b1, 1'b0);
      checkOutput("out_sent_so", 64'(bus.net_so), 64'd1);
      checkOutput("out_sent_do", bus.net_do, 64'h8000_0000_0000_00AA);
      checkOutput("out_status_after", bus.d_out, 64'd0);
      procRead(2'd3, 1'b1, 1'b1);
      checkOutput("out_so_one_cycle", 64'(bus.net_so), 64'd0);
      checkOutput("out_do_holds", bus.net_do, 64'h8000_0000_0000_00AA);

      // Back-pressure with a dropped second write
      procWrite(2'd2, 64'h0000_0000_0000_0055, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i == 2)
            procWrite(2'd2, 64'h0000_0000_0000_1234, 1'b0, i[0]);
         else
            procRead(2'd3, 1'b0, i[0]);
         checkOutput("bp_no_so", 64'(bus.net_so), 64'd0);
      end
      procRead(2'd3, 1'b1, 1'b0);
      checkOutput("bp_still_full", bus.d_out, 64'd1);
      procRead(2'd3, 1'b1, 1'b0);
      checkOutput("bp_sent_so", 64'(bus.net_so), 64'd1);
      checkOutput("bp_sent_original", bus.net_do, 64'h0000_0000_0000_0055);
      procRead(2'd3, 1'b1, 1'b0);
      checkOutput("bp_empty_after", bus.d_out, 64'd0);

      // Inbound overflow keeps the first flit
      routerSend(64'h1111_2222_3333_4444);
      routerSend(64'h5555_6666_7777_8888);
      checkOutput("ovf_net_ri", 64'(bus.net_ri), 64'd0);
      procRead(2'd0, 1'b0, 1'b0);
      checkOutput("ovf_keeps_old", bus.d_out, 64'h1111_2222_3333_4444);
      procRead(2'd1, 1'b0, 1'b0);
      checkOutput("ovf_drained", bus.d_out, 64'd0);

      // Asynchronous reset with both buffers occupied
      applyStimulus(2'd2, 64'h8000_0000_0000_0077, 1'b1, 1'b1, 1'b1, 64'hCAFE_0000_0000_0001, 1'b0, 1'b1);
      procRead(2'd3, 1'b0, 1'b1);
      checkOutput("mid_out_full", bus.d_out, 64'd1);
      checkOutput("mid_in_full", 64'(bus.net_ri), 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_net_ri", 64'(bus.net_ri), 64'd1);
      checkOutput("mid_rst_out_status", bus.d_out, 64'd0);
      checkOutput("mid_rst_net_so", 64'(bus.net_so), 64'd0);
      procRead(2'd1, 1'b0, 1'b1);
      checkOutput("mid_rst_in_status", bus.d_out, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         procRead(2'd3, 1'b1, i[0]);
         checkOutput("mid_no_send", 64'(bus.net_so), 64'd0);
      end

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), {$urandom(), $urandom()},
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
